// File: rtl/detection_result_ctrl.sv
// Detection result controller: collects per-frame bounding boxes from the
// detector into a small buffer, drains them to a ready/valid consumer, and
// manages the SVM bias, frame statistics and sticky alarms.
module detection_result_ctrl #(
  parameter int unsigned                   MAX_BOXES        = 16,
  parameter int unsigned                   CONFIDENCE_WIDTH = 44,
  parameter logic [CONFIDENCE_WIDTH-1:0]   BIAS_RESET       = '0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        vsync,
  input  logic [CONFIDENCE_WIDTH-1:0] cfg_bias,
  input  logic                        cfg_bias_wr,
  output logic [CONFIDENCE_WIDTH-1:0] svm_bias,
  input  logic                        bbox_valid,
  input  logic [15:0]                 bbox_x_start,
  input  logic [15:0]                 bbox_y_start,
  input  logic [15:0]                 bbox_x_end,
  input  logic [15:0]                 bbox_y_end,
  input  logic                        done,
  input  logic [3:0]                  alarm_code,
  input  logic                        alarm_clr,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [15:0]                 m_x_start,
  output logic [15:0]                 m_y_start,
  output logic [15:0]                 m_x_end,
  output logic [15:0]                 m_y_end,
  output logic                        m_last,
  output logic [7:0]                  frame_box_count,
  output logic [7:0]                  frame_drop_count,
  output logic [3:0]                  alarm_sticky,
  output logic                        overrun,
  output logic                        busy
);

  localparam int unsigned AW = $clog2(MAX_BOXES);
  // Stored count must reach MAX_BOXES itself, hence one extra value.
  localparam int unsigned CW = $clog2(MAX_BOXES + 1);

  typedef enum logic [1:0] {StIdle, StCollect, StDrain} state_e;

  state_e                      state_q, state_d;
  logic                        vsync_q;
  logic [CW-1:0]               count_q, count_d;
  logic [7:0]                  drop_q, drop_d;
  logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [7:0]                  fbc_q, fbc_d;
  logic [7:0]                  fdc_q, fdc_d;
  logic [3:0]                  sticky_q, sticky_d;
  logic                        overrun_q, overrun_d;
  logic [CONFIDENCE_WIDTH-1:0] shadow_q, shadow_d;
  logic [CONFIDENCE_WIDTH-1:0] bias_q, bias_d;
  logic [63:0]                 box_mem_q [MAX_BOXES];

  logic          vsync_rise;
  logic          box_fits;
  logic          store;
  logic          drop_inc;
  logic [CW-1:0] count_upd;
  logic [7:0]    drop_upd;
  logic          transfer;
  logic          overrun_set;
  logic [63:0]   rd_word;

  assign vsync_rise = vsync & ~vsync_q;
  assign box_fits   = count_q < CW'(MAX_BOXES);
  assign store      = (state_q == StCollect) & bbox_valid & box_fits;
  assign drop_inc   = (state_q == StCollect) & bbox_valid & ~box_fits;
  // Same-cycle box is folded in before done/vsync closes the frame.
  assign count_upd  = store ? count_q + CW'(1) : count_q;
  assign drop_upd   = (drop_inc && drop_q != 8'hff) ? drop_q + 8'd1 : drop_q;

  assign m_valid  = (state_q == StDrain);
  assign m_last   = m_valid & (CW'(rd_ptr_q) == count_q - CW'(1));
  assign transfer = m_valid & m_ready;
  assign busy     = (state_q != StIdle);

  assign rd_word   = box_mem_q[rd_ptr_q];
  assign m_x_start = rd_word[63:48];
  assign m_y_start = rd_word[47:32];
  assign m_x_end   = rd_word[31:16];
  assign m_y_end   = rd_word[15:0];

  assign frame_box_count  = fbc_q;
  assign frame_drop_count = fdc_q;
  assign alarm_sticky     = sticky_q;
  assign overrun          = overrun_q;
  assign svm_bias         = bias_q;

  // Next-state for the frame FSM, pointers and per-frame statistics.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    drop_d      = drop_q;
    rd_ptr_d    = rd_ptr_q;
    fbc_d       = fbc_q;
    fdc_d       = fdc_q;
    overrun_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (vsync_rise) begin
          state_d = StCollect;
          count_d = '0;
          drop_d  = '0;
        end
      end
      StCollect: begin
        count_d = count_upd;
        drop_d  = drop_upd;
        if (vsync_rise) begin
          // Missing done: close the frame for statistics, drop its boxes.
          fbc_d       = 8'(count_upd);
          fdc_d       = drop_upd;
          overrun_set = 1'b1;
          count_d     = '0;
          drop_d      = '0;
        end else if (done) begin
          fbc_d    = 8'(count_upd);
          fdc_d    = drop_upd;
          rd_ptr_d = '0;
          state_d  = (count_upd != '0) ? StDrain : StIdle;
        end
      end
      StDrain: begin
        if (vsync_rise) begin
          overrun_set = 1'b1;
          state_d     = StCollect;
          count_d     = '0;
          drop_d      = '0;
          rd_ptr_d    = '0;
        end else if (transfer) begin
          rd_ptr_d = rd_ptr_q + AW'(1);
          if (m_last) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Bias shadow/apply and sticky alarm next-state; set beats clear.
  always_comb begin
    shadow_d  = cfg_bias_wr ? cfg_bias : shadow_q;
    bias_d    = bias_q;
    if (vsync_rise) bias_d = cfg_bias_wr ? cfg_bias : shadow_q;
    sticky_d  = (alarm_clr ? 4'b0 : sticky_q) | alarm_code;
    overrun_d = (overrun_q & ~alarm_clr) | overrun_set;
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      vsync_q   <= 1'b0;
      count_q   <= '0;
      drop_q    <= '0;
      rd_ptr_q  <= '0;
      fbc_q     <= '0;
      fdc_q     <= '0;
      sticky_q  <= '0;
      overrun_q <= 1'b0;
      shadow_q  <= BIAS_RESET;
      bias_q    <= BIAS_RESET;
    end else begin
      state_q   <= state_d;
      vsync_q   <= vsync;
      count_q   <= count_d;
      drop_q    <= drop_d;
      rd_ptr_q  <= rd_ptr_d;
      fbc_q     <= fbc_d;
      fdc_q     <= fdc_d;
      sticky_q  <= sticky_d;
      overrun_q <= overrun_d;
      shadow_q  <= shadow_d;
      bias_q    <= bias_d;
    end
  end

  // Box buffer; contents are only meaningful below the stored count.
  always_ff @(posedge clk) begin
    if (store) begin
      box_mem_q[count_q[AW-1:0]] <= {bbox_x_start, bbox_y_start, bbox_x_end, bbox_y_end};
    end
  end

endmodule

// File: doc/detection_result_ctrl.md
DETECTION_RESULT_CTRL -- requirements
Module: detection_result_ctrl

Interface
REQ-001 Parameter MAX_BOXES, default 16, meaning: bounding-box buffer depth per frame (power of 2).
REQ-002 Parameter CONFIDENCE_WIDTH, default 44, meaning: SVM bias/confidence width.
REQ-003 Parameter BIAS_RESET, default 0, meaning: svm_bias value after reset.
REQ-004 Clock and reset: one clock, clk; reset is asynchronous and active-low, reset_n.
REQ-005 Port list, one per line (name  direction  width  meaning):
- clk  in  1  pixel clock
- reset_n  in  1  async active-low reset
- vsync  in  1  video vsync; rising edge = frame start
- cfg_bias  in  CONFIDENCE_WIDTH  host bias value
- cfg_bias_wr  in  1  one-cycle write strobe for cfg_bias
- svm_bias  out  CONFIDENCE_WIDTH  bias driven to detector
- bbox_valid  in  1  detector box strobe
- bbox_x_start, bbox_y_start, bbox_x_end, bbox_y_end  in  16 each  detector box coordinates
- done  in  1  detector end-of-frame strobe
- alarm_code  in  4  detector FIFO-full alarms
- alarm_clr  in  1  clears alarm_sticky and overrun
- m_valid  out  1  output box valid
- m_ready  in  1  consumer ready
- m_x_start, m_y_start, m_x_end, m_y_end  out  16 each  output box
- m_last  out  1  final box of frame
- frame_box_count  out  8  boxes stored last frame
- frame_drop_count  out  8  boxes dropped last frame
- alarm_sticky  out  4  latched alarm_code
- overrun  out  1  sticky: frame start hit undrained boxes
- busy  out  1  state != IDLE

Function
REQ-006 vsync rise detected with one registered vsync_d; rise = vsync & ~vsync_d.
REQ-007 States: IDLE, COLLECT, DRAIN.
REQ-008 IDLE -> COLLECT on vsync rise; buffer write pointer and per-frame counters cleared on that edge.
REQ-009 COLLECT: each bbox_valid cycle writes the 4 coordinates at write pointer if count < MAX_BOXES; otherwise box discarded, drop counter +1, saturating at 255.
REQ-010 COLLECT -> DRAIN on done with stored count > 0; COLLECT -> IDLE on done with count 0; frame_box_count/frame_drop_count load on that edge.
REQ-011 bbox_valid and done in same cycle: box is stored/counted first and included in the frame.
REQ-012 DRAIN: m_valid high from first DRAIN cycle; box at read pointer presented combinationally from buffer; transfer when m_valid & m_ready; read pointer +1 per transfer.
REQ-013 m_valid held and m_* stable until transfer; m_valid never deasserts without transfer except per REQ-014.
REQ-014 m_last = m_valid & (read pointer == stored count - 1); transfer with m_last -> IDLE.
REQ-015 vsync rise in DRAIN: untransferred boxes discarded, m_valid low next cycle, overrun set, -> COLLECT with counters cleared.
REQ-016 vsync rise in COLLECT (done missing): frame closed as if done plus overrun set, then -> COLLECT for new frame; stored boxes discarded.
REQ-017 Bias: cfg_bias_wr loads shadow register; svm_bias loads shadow on vsync rise only; cfg_bias_wr on the same cycle as vsync rise forwards cfg_bias directly to svm_bias.
REQ-018 alarm_sticky |= alarm_code each cycle; alarm_clr zeroes alarm_sticky and overrun; simultaneous set and clr -> set wins for asserted bits.
REQ-019 busy = 1 in COLLECT and DRAIN.

Reset
REQ-020 reset_n low asynchronously: state IDLE, pointers/counters 0, m_valid 0, m_last 0, frame_box_count 0, frame_drop_count 0, alarm_sticky 0, overrun 0, svm_bias and shadow = BIAS_RESET, vsync_d 0.
REQ-021 Reset mid-DRAIN or mid-COLLECT discards all buffered boxes; no transfer after deassertion until a new frame completes.

Verification
REQ-022 vsync rise, 3 bbox_valid (boxes A,B,C), done, m_ready=1 -> A,B,C out on 3 consecutive cycles, m_last only with C, frame_box_count=3, then IDLE.
REQ-023 MAX_BOXES=16, 20 boxes in one frame -> 16 stored, frame_drop_count=4, first 16 boxes drained in order.
REQ-024 m_ready toggled 1/0 during drain of 5 boxes -> m_* stable while m_ready=0, no loss or duplication, 5 transfers.
REQ-025 vsync rise with 2 of 4 boxes drained -> m_valid low next cycle, overrun=1, next frame's boxes drain normally; alarm_clr -> overrun=0.
REQ-026 cfg_bias=0x123 written mid-frame -> svm_bias unchanged until next vsync rise, then 0x123; write coincident with vsync rise -> applied that edge.
REQ-027 alarm_code=4'b0100 for one cycle -> alarm_sticky=4'b0100 held; alarm_clr with alarm_code=4'b0001 same cycle -> alarm_sticky=4'b0001.
